// File: rtl/gpr_wb_arbiter_if.sv
// Write-back bus between the two GPR write sources, the hazard query port
// and the single GPR write port.
interface gpr_wb_arbiter_if;
    logic        P_Valid;
    logic [4:0]  P_Reg;
    logic [31:0] P_Data;
    logic        S_Valid;
    logic [4:0]  S_Reg;
    logic [31:0] S_Data;
    logic        S_Ready;
    logic [4:0]  QReg1;
    logic [4:0]  QReg2;
    logic        Pend1;
    logic        Pend2;
    logic [4:0]  WReg;
    logic        RegWrite;
    logic [31:0] WData;

    // Handshake: a secondary write transfers on a rising Clk edge where
    // S_Valid && S_Ready; S_Ready depends only on the FIFO fill level.
    // The primary source has no backpressure.
    modport slave (
        input  P_Valid, P_Reg, P_Data,
        input  S_Valid, S_Reg, S_Data,
        output S_Ready,
        input  QReg1, QReg2,
        output Pend1, Pend2,
        output WReg, RegWrite, WData
    );

    modport master (
        output P_Valid, P_Reg, P_Data,
        output S_Valid, S_Reg, S_Data,
        input  S_Ready,
        output QReg1, QReg2,
        input  Pend1, Pend2,
        input  WReg, RegWrite, WData
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Merges the in-order pipeline (priority) and a FIFO-buffered multi-cycle
// unit onto the single GPR write port, with hazard reporting for decode.
module gpr_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    gpr_wb_arbiter_if.slave  bus
);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_reg  [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic        reg_write;
    logic [4:0]  w_reg;
    logic [31:0] w_data;

    logic p_active;
    logic s_ready;
    logic push;
    logic pop;
    logic s_keep;
    logic pend1;
    logic pend2;

    assign p_active = bus.P_Valid && (bus.P_Reg != 5'd0);
    assign s_ready  = (count != CNT_FULL);
    assign push     = bus.S_Valid && s_ready;
    assign pop      = !p_active && (count != '0);
    // A same-cycle primary write to the same register is newer, so the
    // incoming secondary entry is born squashed.
    assign s_keep   = (bus.S_Reg != 5'd0) && !(p_active && bus.S_Reg == bus.P_Reg);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i]  <= 5'd0;
                ent_data[i] <= 32'd0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            reg_write <= 1'b0;
            w_reg     <= 5'd0;
            w_data    <= 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && tail == PTR_W'(i)) begin
                    ent_valid[i] <= s_keep;
                    ent_reg[i]   <= bus.S_Reg;
                    ent_data[i]  <= bus.S_Data;
                end else if ((p_active && ent_reg[i] == bus.P_Reg) ||
                             (pop && head == PTR_W'(i))) begin
                    ent_valid[i] <= 1'b0;
                end
            end

            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // A squashed head still costs its pop cycle as a bubble.
            if (p_active) begin
                reg_write <= 1'b1;
                w_reg     <= bus.P_Reg;
                w_data    <= bus.P_Data;
            end else if (pop && ent_valid[head]) begin
                reg_write <= 1'b1;
                w_reg     <= ent_reg[head];
                w_data    <= ent_data[head];
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_reg[i] == bus.QReg1) pend1 = 1'b1;
            if (ent_valid[i] && ent_reg[i] == bus.QReg2) pend2 = 1'b1;
        end
        if (reg_write && w_reg == bus.QReg1) pend1 = 1'b1;
        if (reg_write && w_reg == bus.QReg2) pend2 = 1'b1;
        if (bus.QReg1 == 5'd0) pend1 = 1'b0;
        if (bus.QReg2 == 5'd0) pend2 = 1'b0;
    end

    assign bus.S_Ready  = s_ready;
    assign bus.Pend1    = pend1;
    assign bus.Pend2    = pend2;
    assign bus.RegWrite = reg_write;
    assign bus.WReg     = w_reg;
    assign bus.WData    = w_data;
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Write-side front end for the 32x32 general-purpose register file. It merges two write-back sources into the single GPR write port (WReg/RegWrite/WData):
  - the in-order main pipeline (primary, never stalled);
  - the multi-cycle unit (mult/div, late loads), which is secondary, valid/ready handshaked and buffered in a FIFO.
- Drops writes to register 0.
- Reports pending writes so decode can stall on register hazards.

Parameters:
- DEPTH, 4: secondary FIFO entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- P_Valid  in  1  primary write request this cycle.
- P_Reg  in  5  primary destination register.
- P_Data  in  32  primary write data.
- S_Valid  in  1  secondary write offered.
- S_Reg  in  5  secondary destination register.
- S_Data  in  32  secondary write data.
- S_Ready  out  1  FIFO can accept; transfer occurs when S_Valid && S_Ready at the rising edge.
- QReg1  in  5  hazard query register 1.
- QReg2  in  5  hazard query register 2.
- Pend1  out  1  write to QReg1 is pending (queued or in the output stage).
- Pend2  out  1  same, for QReg2.
- WReg  out  5  to GPR write-register input; registered.
- RegWrite  out  1  to GPR write-enable input; registered.
- WData  out  32  to GPR write-data input; registered.

Behaviour:
- Reset (async, any time, including mid-drain):
  - FIFO emptied, count=0, all entry valid bits cleared.
  - RegWrite=0, WReg=0, WData=0.
  - Pending and in-flight writes are discarded.
  - After reset: S_Ready=1, Pend1=Pend2=0.
- FIFO: DEPTH entries of {valid, reg[4:0], data[31:0]}; head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- S_Ready = (count != DEPTH), a function of count only. At full, no push is accepted even in a cycle that pops.
- Push: on S_Valid && S_Ready, the entry is written at tail with valid = (S_Reg != 0); tail and count advance.
- Slot selection each cycle (exactly one write per edge at most):
  - Primary active (P_Valid && P_Reg != 0): output stage loads RegWrite=1, WReg=P_Reg, WData=P_Data. No pop.
  - Otherwise, if count > 0: pop head. If head valid, load RegWrite=1 with head reg/data. If head squashed, RegWrite=0 (bubble cycle).
  - Otherwise: RegWrite=0. WReg/WData hold their previous values.
- Latency:
  - Primary reaches GPR inputs 1 cycle after request, and is committed into the GPR at the following edge.
  - Secondary takes at least 1 cycle after push; it waits while primary is active. Starvation is permitted by design.
- Ordering / squash:
  - An active primary write to R invalidates every queued valid entry with reg R at that edge.
  - A secondary entry pushed in the same cycle with reg R is treated as older and is stored invalid.
  - Result: the GPR never receives an older secondary value after a newer primary value.
- Secondary entries drain strictly FIFO.
- Push and pop in the same cycle (count < DEPTH): count unchanged, both pointers advance.
- Pend logic (combinational):
  - PendN = (QRegN != 0) && (any valid FIFO entry with reg == QRegN, or (RegWrite && WReg == QRegN)).
  - The same-cycle incoming S and P requests are not included.
- Register 0: never written (RegWrite never 1 with WReg=0) and never reported pending.

Test Plan:
- Reset then idle 3 cycles -> RegWrite=0, WReg=0, WData=0, S_Ready=1, Pend1=Pend2=0 every cycle.
- P_Valid=1, P_Reg=5, P_Data=32'h1234_5678 for one cycle -> next cycle RegWrite=1, WReg=5, WData=32'h1234_5678; the cycle after, RegWrite=0.
- With P_Valid held 1 (P_Reg=3): push S entries (reg 8, 9, 10, 11) -> S_Ready=0 after the 4th push; QReg1=9 gives Pend1=1. Release P -> four consecutive writes 8, 9, 10, 11 in order, then S_Ready=1.
- Queue S reg 7 data 32'hAAAA_AAAA while P busy on reg 2, then P writes reg 7 data 32'hBBBB_BBBB -> the queued entry is squashed: a bubble cycle with RegWrite=0, and the only write to reg 7 is 32'hBBBB_BBBB.
- P_Reg=0 and S push with reg 0 -> no RegWrite pulse for either; Pend1=0 with QReg1=0.
- Assert Reset asynchronously (mid-cycle) with 3 entries queued -> outputs go 0 immediately, without waiting for a clock edge; after release, no queued write ever appears and S_Ready=1.
